fwd_hazard_ctrl: RTL and testbench

FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

---
 rtl/fwd_hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use hazard controller for a 5-stage pipeline.
// Optional stall statistics counter: define FWD_HAZARD_STALL_STATS_EN.
module fwd_hazard_ctrl #(
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        id_valid,
    input  logic [NUM_SRC*REG_AW-1:0]   id_rs,
    input  logic [NUM_SRC*REG_AW-1:0]   ex_rs,
    input  logic [REG_AW-1:0]           ex_rd,
    input  logic                        ex_RegWr,
    input  logic                        ex_MemRd,
    input  logic [REG_AW-1:0]           mem_rd,
    input  logic                        mem_RegWr,
    input  logic [REG_AW-1:0]           wb_rd,
    input  logic                        wb_RegWr,
    input  logic                        flush,
    output logic [NUM_SRC*2-1:0]        fwd_sel,
    output logic                        stall_if_id,
    output logic                        bubble_ex,
    output logic [15:0]                 stall_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    // The hit cycle itself is the first stall cycle, so STALL covers LOAD_LAT-1 more.
    localparam logic [1:0] CNT_INIT = (LOAD_LAT > 1) ? 2'(LOAD_LAT - 2) : 2'd0;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_cnt;
    logic [1:0]  w_cnt_nxt;
    logic        w_src_match;
    logic        w_hit;
    logic        w_stall;

    always_comb begin
        fwd_sel = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (mem_RegWr && (mem_rd != '0) && (mem_rd == ex_rs[k*REG_AW +: REG_AW])) begin
                fwd_sel[k*2 +: 2] = 2'b10;
            end else if (wb_RegWr && (wb_rd != '0) && (wb_rd == ex_rs[k*REG_AW +: REG_AW])) begin
                fwd_sel[k*2 +: 2] = 2'b01;
            end
        end
    end

    always_comb begin
        w_src_match = 1'b0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (ex_rd == id_rs[k*REG_AW +: REG_AW]) begin
                w_src_match = 1'b1;
            end
        end
        w_hit = id_valid && ex_MemRd && ex_RegWr && (ex_rd != '0) && w_src_match;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (flush) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hit && (LOAD_LAT > 1)) begin
                        w_state_nxt = STALL;
                        w_cnt_nxt   = CNT_INIT;
                    end
                end
                STALL: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - 2'd1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Gated by rst_n so the Mealy hit path stays quiet while reset is held.
    always_comb begin
        w_stall     = rst_n && !flush && ((r_state == STALL) || w_hit);
        stall_if_id = w_stall;
        bubble_ex   = w_stall;
    end

`ifdef FWD_HAZARD_STALL_STATS_EN
    logic [15:0] r_stall_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign stall_count = r_stall_count;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed scoreboard bench for fwd_hazard_ctrl at LOAD_LAT = 1, 2 and 3 side by side.
module tb_fwd_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [9:0]  id_rs;
    logic [9:0]  ex_rs;
    logic [4:0]  ex_rd;
    logic        ex_RegWr;
    logic        ex_MemRd;
    logic [4:0]  mem_rd;
    logic        mem_RegWr;
    logic [4:0]  wb_rd;
    logic        wb_RegWr;
    logic        flush;

    logic [3:0]  fwd1, fwd2, fwd3;
    logic        st1, st2, st3;
    logic        bb1, bb2, bb3;
    logic [15:0] sc1, sc2, sc3;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    typedef struct {
        string    tag;
        logic [3:0] fwd;
        logic [2:0] stall;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] esc [3];

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(.NUM_SRC(2), .REG_AW(5), .LOAD_LAT(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .ex_rs(ex_rs),
        .ex_rd(ex_rd), .ex_RegWr(ex_RegWr), .ex_MemRd(ex_MemRd), .mem_rd(mem_rd),
        .mem_RegWr(mem_RegWr), .wb_rd(wb_rd), .wb_RegWr(wb_RegWr), .flush(flush),
        .fwd_sel(fwd1), .stall_if_id(st1), .bubble_ex(bb1), .stall_count(sc1)
    );

    fwd_hazard_ctrl #(.NUM_SRC(2), .REG_AW(5), .LOAD_LAT(2)) u_l2 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .ex_rs(ex_rs),
        .ex_rd(ex_rd), .ex_RegWr(ex_RegWr), .ex_MemRd(ex_MemRd), .mem_rd(mem_rd),
        .mem_RegWr(mem_RegWr), .wb_rd(wb_rd), .wb_RegWr(wb_RegWr), .flush(flush),
        .fwd_sel(fwd2), .stall_if_id(st2), .bubble_ex(bb2), .stall_count(sc2)
    );

    fwd_hazard_ctrl #(.NUM_SRC(2), .REG_AW(5), .LOAD_LAT(3)) u_l3 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .ex_rs(ex_rs),
        .ex_rd(ex_rd), .ex_RegWr(ex_RegWr), .ex_MemRd(ex_MemRd), .mem_rd(mem_rd),
        .mem_RegWr(mem_RegWr), .wb_rd(wb_rd), .wb_RegWr(wb_RegWr), .flush(flush),
        .fwd_sel(fwd3), .stall_if_id(st3), .bubble_ex(bb3), .stall_count(sc3)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] exp_count(input int unsigned i);
`ifdef FWD_HAZARD_STALL_STATS_EN
        return rst_n ? esc[i] : 16'd0;
`else
        return 16'd0;
`endif
    endfunction

    task automatic clr();
        id_valid  = 1'b0; id_rs    = '0; ex_rs    = '0; ex_rd  = '0;
        ex_RegWr  = 1'b0; ex_MemRd = 1'b0; mem_rd = '0; mem_RegWr = 1'b0;
        wb_rd     = '0;   wb_RegWr = 1'b0; flush  = 1'b0;
    endtask

    task automatic load_hit(input logic [4:0] rs1, input logic [4:0] rs0);
        id_valid = 1'b1; ex_MemRd = 1'b1; ex_RegWr = 1'b1; ex_rd = 5'd7;
        id_rs    = {rs1, rs0};
    endtask

    // Push expectation for the cycle just driven, then compare at the falling edge.
    task automatic tick(input string tag, input logic [3:0] efwd, input logic [2:0] est);
        exp_t e;
        e.tag = tag; e.fwd = efwd; e.stall = est;
        sb.push_back(e);
        @(negedge clk);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 16'd1, 16'd0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_fwd1"}, 16'(fwd1), 16'(e.fwd));
            chk({e.tag, "_fwd2"}, 16'(fwd2), 16'(e.fwd));
            chk({e.tag, "_fwd3"}, 16'(fwd3), 16'(e.fwd));
            chk({e.tag, "_stall1"}, 16'(st1), 16'(e.stall[0]));
            chk({e.tag, "_stall2"}, 16'(st2), 16'(e.stall[1]));
            chk({e.tag, "_stall3"}, 16'(st3), 16'(e.stall[2]));
            chk({e.tag, "_bub1"}, 16'(bb1), 16'(e.stall[0]));
            chk({e.tag, "_bub2"}, 16'(bb2), 16'(e.stall[1]));
            chk({e.tag, "_bub3"}, 16'(bb3), 16'(e.stall[2]));
            chk({e.tag, "_cnt1"}, sc1, exp_count(0));
            chk({e.tag, "_cnt2"}, sc2, exp_count(1));
            chk({e.tag, "_cnt3"}, sc3, exp_count(2));
            for (int i = 0; i < 3; i++) begin
                if (!rst_n) esc[i] = 16'd0;
                else if (e.stall[i] && esc[i] != 16'hFFFF) esc[i] = esc[i] + 16'd1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) esc[i] = 16'd0;
        clr();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // Reset: hit present but stall masked, forwarding still live
        load_hit(5'd7, 5'd2);
        ex_rs = {5'd9, 5'd5}; mem_rd = 5'd5; mem_RegWr = 1'b1;
        tick("reset_hold", 4'b0010, 3'b000);
        rst_n = 1'b1;
        clr();

        // Forwarding priority
        ex_rs = {5'd9, 5'd5}; mem_rd = 5'd5; mem_RegWr = 1'b1; wb_rd = 5'd5; wb_RegWr = 1'b1;
        tick("fwd_mem_pri", 4'b0010, 3'b000);
        mem_RegWr = 1'b0;
        tick("fwd_wb", 4'b0001, 3'b000);
        mem_RegWr = 1'b1; mem_rd = '0; wb_rd = '0;
        tick("fwd_rd0", 4'b0000, 3'b000);
        ex_rs = {5'd3, 5'd5}; mem_rd = 5'd3; wb_rd = 5'd5;
        tick("fwd_mixed", 4'b1001, 3'b000);
        mem_rd = 5'd5; wb_RegWr = 1'b0;
        tick("fwd_wb_off", 4'b0010, 3'b000);
        clr();

        // Single load-use: stall lengths 1 / 2 / 3
        load_hit(5'd7, 5'd2);
        tick("lu_c0", 4'b0000, 3'b111);
        clr();
        tick("lu_c1", 4'b0000, 3'b110);
        tick("lu_c2", 4'b0000, 3'b100);
        tick("lu_c3", 4'b0000, 3'b000);

        // Clean counters, then back-to-back stalls with a dual-source match on the second
        rst_n = 1'b0;
        tick("rst_pulse1", 4'b0000, 3'b000);
        rst_n = 1'b1;
        load_hit(5'd7, 5'd2);
        tick("b2b_a", 4'b0000, 3'b111);
        clr();
        tick("b2b_b", 4'b0000, 3'b110);
        load_hit(5'd7, 5'd7);
        tick("b2b_c", 4'b0000, 3'b111);
        clr();
        tick("b2b_d", 4'b0000, 3'b010);
        tick("b2b_e", 4'b0000, 3'b000);
`ifdef FWD_HAZARD_STALL_STATS_EN
        chk("l2_count_b2b", sc2, 16'd4);
`else
        chk("l2_count_b2b", sc2, 16'd0);
`endif

        // Flush on second stall cycle, then flush racing a hit
        load_hit(5'd0, 5'd7);
        tick("fl_a", 4'b0000, 3'b111);
        clr(); flush = 1'b1;
        tick("fl_b", 4'b0000, 3'b000);
        flush = 1'b0;
        tick("fl_c", 4'b0000, 3'b000);
        load_hit(5'd7, 5'd0); flush = 1'b1;
        tick("fl_hit", 4'b0000, 3'b000);
        clr();
        tick("fl_after", 4'b0000, 3'b000);

        // Reset mid-stall aborts immediately
        load_hit(5'd7, 5'd2);
        tick("rs_a", 4'b0000, 3'b111);
        clr(); rst_n = 1'b0;
        tick("rs_b", 4'b0000, 3'b000);
        rst_n = 1'b1;
        tick("rs_c", 4'b0000, 3'b000);
        chk("count_after_rst", sc3, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
